// File: rtl/multdiv_sequencer.sv
// Control sequencer for the shared iterative multiply/divide datapath.
// Optional abort-on-new-start behaviour is enabled by defining MULTDIV_ABORT_EN.
module multdiv_sequencer #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             mult_ovf,
  output logic             load,
  output logic             mult_step,
  output logic             div_step,
  output logic [CNT_W-1:0] step_idx,
  output logic             last_step,
  output logic             busy,
  output logic             op_is_div,
  output logic             resultRDY,
  output logic             exception
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef MULTDIV_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             op_div;
  logic             op_div_nxt;
  logic             dz_exc;
  logic             dz_exc_nxt;
  logic             start;
  logic             start_div;
  logic             at_last;

  // Multiply has priority when both start pulses arrive together.
  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign at_last   = (cnt == (op_div ? DIV_LAST : MULT_LAST));

  // State, counter and latched operation registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      cnt    <= {CNT_W{1'b0}};
      op_div <= 1'b0;
      dz_exc <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      op_div <= op_div_nxt;
      dz_exc <= dz_exc_nxt;
    end
  end

  // Next-state and counter logic; counter is zero everywhere except RUN.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = {CNT_W{1'b0}};
    op_div_nxt = op_div;
    dz_exc_nxt = dz_exc;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_LOAD;
          op_div_nxt = start_div;
          dz_exc_nxt = 1'b0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (ABORT_EN && start) begin
          state_nxt  = S_LOAD;
          op_div_nxt = start_div;
          dz_exc_nxt = 1'b0;
        end else if (op_div && divisor_zero) begin
          state_nxt  = S_DONE;
          dz_exc_nxt = 1'b1;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (ABORT_EN && start) begin
          state_nxt  = S_LOAD;
          op_div_nxt = start_div;
          dz_exc_nxt = 1'b0;
        end else if (at_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt  = S_LOAD;
          op_div_nxt = start_div;
          dz_exc_nxt = 1'b0;
        end else begin
          state_nxt  = S_IDLE;
          op_div_nxt = 1'b0;
          dz_exc_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        op_div_nxt = 1'b0;
        dz_exc_nxt = 1'b0;
      end
    endcase
  end

  // Output decode from registered state; only exception sees an input (mult_ovf).
  always_comb begin
    load      = 1'b0;
    mult_step = 1'b0;
    div_step  = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    resultRDY = 1'b0;
    exception = 1'b0;
    step_idx  = cnt;
    op_is_div = op_div;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_RUN: begin
        mult_step = ~op_div;
        div_step  = op_div;
        last_step = at_last;
        busy      = 1'b1;
      end
      S_DONE: begin
        resultRDY = 1'b1;
        exception = op_div ? dz_exc : mult_ovf;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: vector table plus hand sequences,
// with a result scoreboard keyed on the expected resultRDY cycle.
module tb_multdiv_sequencer;
  localparam int MS = 16;
  localparam int DS = 32;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic clr, ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf;
  logic load, mult_step, div_step, last_step, busy, op_is_div, resultRDY, exception;
  logic [CW-1:0] step_idx;
  logic [11:0] obs;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    logic exc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic m;
    logic d;
    logic dz;
    logic ovf;
    logic ediv;
    int   lat;
    logic exc;
  } vec_t;
  vec_t tbl[7];

  multdiv_sequencer #(.MULT_STEPS(MS), .DIV_STEPS(DS), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .divisor_zero(divisor_zero), .mult_ovf(mult_ovf), .load(load),
    .mult_step(mult_step), .div_step(div_step), .step_idx(step_idx),
    .last_step(last_step), .busy(busy), .op_is_div(op_is_div),
    .resultRDY(resultRDY), .exception(exception)
  );

  assign obs = {load, mult_step, div_step, last_step, busy, op_is_div, step_idx};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] ev(input logic l, input logic ms, input logic dv,
                                     input logic ls, input logic b, input logic od,
                                     input int idx);
    logic [31:0] t;
    t = idx;
    return {l, ms, dv, ls, b, od, t[CW-1:0]};
  endfunction

  task automatic check_vec(input string nm, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (load,ms,ds,last,busy,div,idx)", nm, cyc, obs, exp);
    end
  endtask

  // Scoreboard: every resultRDY must match the front entry's cycle and exception.
  always @(negedge clk) begin
    exp_t e;
    if (resultRDY === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdy cyc=%0d exc=%b", cyc, exception);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || exception !== e.exc) begin
          errors++;
          $display("FAIL rdy cyc=%0d exc=%b expected cyc=%0d exc=%b", cyc, exception, e.cyc, e.exc);
        end
      end
    end
  end

  task automatic run_op(input vec_t v);
    exp_t e;
    ctrl_MULT = v.m; ctrl_DIV = v.d; divisor_zero = v.dz; mult_ovf = v.ovf;
    e.cyc = cyc + v.lat; e.exc = v.exc;
    sb.push_back(e);
    @(negedge clk);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    for (int c = 1; c <= v.lat; c++) begin
      if (c == 1)
        check_vec("load", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, v.ediv, 0));
      else if (c < v.lat)
        check_vec("run", ev(1'b0, ~v.ediv, v.ediv, (c == v.lat - 1), 1'b1, v.ediv, c - 2));
      else
        check_vec("done", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v.ediv, 0));
      @(negedge clk);
    end
    check_vec("idle_after", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    divisor_zero = 1'b0; mult_ovf = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    tbl[0] = '{m:1'b1, d:1'b0, dz:1'b0, ovf:1'b0, ediv:1'b0, lat:MS+2, exc:1'b0};
    tbl[1] = '{m:1'b1, d:1'b0, dz:1'b0, ovf:1'b1, ediv:1'b0, lat:MS+2, exc:1'b1};
    tbl[2] = '{m:1'b0, d:1'b1, dz:1'b0, ovf:1'b0, ediv:1'b1, lat:DS+2, exc:1'b0};
    tbl[3] = '{m:1'b0, d:1'b1, dz:1'b1, ovf:1'b0, ediv:1'b1, lat:2,    exc:1'b1};
    tbl[4] = '{m:1'b1, d:1'b1, dz:1'b0, ovf:1'b0, ediv:1'b0, lat:MS+2, exc:1'b0};
    tbl[5] = '{m:1'b1, d:1'b1, dz:1'b1, ovf:1'b1, ediv:1'b0, lat:MS+2, exc:1'b1};
    tbl[6] = '{m:1'b0, d:1'b1, dz:1'b0, ovf:1'b1, ediv:1'b1, lat:DS+2, exc:1'b0};

    clr = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; divisor_zero = 1'b0; mult_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("reset", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    checks++;
    if ({resultRDY, exception} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rdy got=%b exp=00", {resultRDY, exception});
    end
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_vec("quiet", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    end

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i]);
      repeat (2) @(negedge clk);
    end

    // Contention: both pulses start a multiply; a divide pulse arrives in cycle 10.
    ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
`ifdef MULTDIV_ABORT_EN
    e.cyc = cyc + 44;
`else
    e.cyc = cyc + MS + 2;
`endif
    e.exc = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    repeat (9) @(negedge clk);
    check_vec("cont_c10", ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8));
    ctrl_DIV = 1'b1;
    @(negedge clk);
    ctrl_DIV = 1'b0;
`ifdef MULTDIV_ABORT_EN
    check_vec("abort_load", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    @(negedge clk);
    check_vec("abort_run0", ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0));
    repeat (33) @(negedge clk);
`else
    check_vec("ignored_c11", ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9));
    repeat (8) @(negedge clk);
`endif
    check_vec("cont_idle", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(negedge clk);

    // Back-to-back: divide pulse in the DONE cycle of a multiply.
    ctrl_MULT = 1'b1;
    e.cyc = cyc + MS + 2; e.exc = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    ctrl_MULT = 1'b0;
    repeat (17) @(negedge clk);
    check_vec("b2b_done", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    ctrl_DIV = 1'b1;
    e.cyc = cyc + DS + 2; e.exc = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    ctrl_DIV = 1'b0;
    check_vec("b2b_load", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0));
    repeat (34) @(negedge clk);
    check_vec("b2b_idle", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(negedge clk);

    // Mid-run clear with a coincident start pulse that must be dropped.
    ctrl_MULT = 1'b1;
    @(negedge clk);
    ctrl_MULT = 1'b0;
    repeat (4) @(negedge clk);
    check_vec("clr_c5", ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3));
    clr = 1'b1; ctrl_DIV = 1'b1;
    @(negedge clk);
    clr = 1'b0; ctrl_DIV = 1'b0;
    check_vec("clr_c6", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    repeat (30) @(negedge clk);
    check_vec("clr_later", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Control sequencer for the iterative multiply/divide datapath. Accepts single-cycle start pulses from the processor, keeps the datapath's load and step enables in order with a step counter, and raises a one-cycle result-ready pulse with an exception flag. It sits between the execute stage and the shared multiplier/divider registers, so multiply and divide never drive the datapath at the same time.

## Interface
- MULT_STEPS, 16: multiply iterations (radix-4 Booth, 32-bit operands)
- DIV_STEPS, 32: divide iterations (restoring, 1 bit per step)
- CNT_W, 6: step counter width; must satisfy 2^CNT_W > max(MULT_STEPS, DIV_STEPS)

- clk  in  1  sole clock; all state changes on the rising edge
- clr  in  1  synchronous, active-high reset
- ctrl_MULT  in  1  start multiply, one-cycle pulse
- ctrl_DIV  in  1  start divide, one-cycle pulse
- divisor_zero  in  1  from datapath: latched divisor == 0; valid in the LOAD cycle
- mult_ovf  in  1  from datapath: multiply overflow; valid in the DONE cycle
- load  out  1  datapath latches operands and clears the accumulator
- mult_step  out  1  advance the multiply datapath one iteration
- div_step  out  1  advance the divide datapath one iteration
- step_idx  out  CNT_W  current iteration index, 0-based
- last_step  out  1  high during the final step cycle
- busy  out  1  high in LOAD or RUN
- op_is_div  out  1  registered operation type of the current or most recent operation
- resultRDY  out  1  one-cycle result-valid pulse
- exception  out  1  valid only while resultRDY is 1

## Operation
- States:
  - IDLE: waiting for a start pulse.
  - LOAD: one cycle; asserts `load`.
  - RUN: stepping; asserts `mult_step` or `div_step`.
  - DONE: one cycle; asserts `resultRDY`.
- IDLE -> LOAD when ctrl_MULT or ctrl_DIV is 1.
  - If both are 1 in the same cycle, multiply wins and op_is_div = 0.
  - The operation type is latched into op_is_div on this edge.
- LOAD -> DONE with exception=1 if op_is_div and divisor_zero (early exit, no steps).
- LOAD -> RUN otherwise; step_idx is cleared to 0.
- RUN:
  - mult_step = !op_is_div and div_step = op_is_div; exactly one is high every RUN cycle.
  - step_idx increments each cycle.
  - last_step = 1 when step_idx == N-1 (N = MULT_STEPS or DIV_STEPS).
  - After the step_idx = N-1 cycle, go to DONE.
- DONE:
  - resultRDY = 1.
  - exception = mult_ovf for multiply, 0 for a divide that ran normally.
  - Next state is LOAD if a start pulse is present this cycle (back-to-back, no IDLE bubble), otherwise IDLE.
- Start pulses during LOAD or RUN are ignored (no queueing), unless the abort feature below is compiled in.
- Output reset values, and values in IDLE: load, mult_step, div_step, last_step, busy, resultRDY, exception = 0; step_idx = 0; op_is_div = 0.
- All outputs decode from registered state and the counter; no input-to-output combinational path except exception from mult_ovf in DONE.

## Timing
- Start sampled at edge E0. The LOAD cycle follows E0.
- RUN lasts N cycles after LOAD. DONE follows RUN.
- resultRDY is high in cycle N+2 counting from E0 = 0:
  - multiply: cycle 18
  - divide: cycle 34
  - divide by zero: cycle 2
- Throughput with back-to-back pulses issued in DONE: one operation per N+2 cycles.
- clr asserted in any cycle, including mid-RUN or DONE:
  - next state is IDLE and all outputs take reset values on the following cycle;
  - any pending resultRDY is suppressed;
  - a start pulse coincident with clr is dropped.
- The step counter never wraps. It is held at 0 outside RUN.

## Configuration
- MULTDIV_ABORT_EN defined: a start pulse in LOAD or RUN aborts the current operation.
  - The next state is LOAD with the new op_is_div and step_idx = 0.
  - No resultRDY is issued for the aborted operation.
- MULTDIV_ABORT_EN undefined: start pulses while busy are ignored, and the current operation completes normally.

## Test plan
- Reset: hold clr 2 cycles -> all outputs 0 and step_idx = 0. Release clr, drive no pulses for 5 cycles -> outputs stay 0.
- Multiply: pulse ctrl_MULT at E0 ->
  - load = 1 in cycle 1;
  - mult_step = 1 in cycles 2-17 with step_idx 0..15;
  - last_step = 1 in cycle 17;
  - resultRDY = 1 in cycle 18 only, with exception = mult_ovf (check both 0 and 1).
- Divide: pulse ctrl_DIV ->
  - div_step = 1 for 32 cycles and mult_step never high;
  - resultRDY in cycle 34, exception = 0.
- Divide by zero: pulse ctrl_DIV with divisor_zero = 1 in LOAD -> resultRDY and exception both 1 in cycle 2, with no step pulses.
- Contention: ctrl_MULT and ctrl_DIV together -> multiply runs.
  - Pulse ctrl_DIV in cycle 10 of the run. Without MULTDIV_ABORT_EN: ignored, resultRDY in cycle 18.
  - With MULTDIV_ABORT_EN: LOAD in cycle 11, divide completes in cycle 44, and no resultRDY in cycle 18.
- Back-to-back and mid-operation reset:
  - ctrl_DIV pulsed in the DONE cycle of a multiply -> LOAD immediately on the next cycle.
  - clr in RUN cycle 5 -> IDLE next cycle, and no resultRDY ever appears for that operation.
